// File: rtl/spike_pkg.sv
// Shared definitions for the spike event buffer.
//  - Default geometry: FIFO depth, neuron index width, spike counter width.
//  - Event-word field offsets for the default index width.
//  - Sweep FSM state encodings.
package spike_pkg;

  localparam int SPK_DEPTH = 16;
  localparam int SPK_IDX_W = 8;
  localparam int SPK_CNT_W = 9;

  // Event word layout: {eos, spk, idx}
  localparam int IDX_LSB = 0;
  localparam int SPK_BIT = SPK_IDX_W;
  localparam int EOS_BIT = SPK_IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//  Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   wr_en_i, wr_data_i write request and data (ignored when full)
//   rd_en_i            pop the head word (ignored when empty)
//   rd_data_o          head word, forced to zero while empty
//   full_o, empty_o    occupancy flags derived from the pointers
//  Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             wr_do_s;
  logic             rd_do_s;

  assign full_o  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty_o = (wr_ptr_r == rd_ptr_r);
  assign wr_do_s = wr_en_i && !full_o;
  assign rd_do_s = rd_en_i && !empty_o;

  // Head word is zeroed when empty so stale storage never leaks out.
  assign rd_data_o = empty_o ? {WIDTH{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

  // Pointer registers; wrap naturally modulo 2*DEPTH.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
    end else begin
      if (wr_do_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (rd_do_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (wr_do_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/spike_event_buffer.sv
// Spike event buffer: queues spiking-neuron indices and one end-of-sweep
// marker per image, drained by the output router over valid/ready.
//  Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   new_image_packet_i   clears spike count and overflow (FIFO kept)
//   spike_valid_i        neuron result valid; spike_i = fired
//   neuron_idx_i         index of the reported neuron
//   last_neuron_i        final neuron of the sweep
//   evt_valid_o/ready_i  FWFT handshake; evt_data_o = {eos, spk, idx}
//   spike_count_o        accepted spikes this image, saturating
//   overflow_o           sticky: a push was dropped on a full FIFO
//   busy_o               FSM not idle
//   sweep_done_o         one-cycle pulse when a sweep has fully drained
module spike_event_buffer
  import spike_pkg::*;
#(
  parameter int DEPTH = SPK_DEPTH,
  parameter int IDX_W = SPK_IDX_W,
  parameter int CNT_W = SPK_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             new_image_packet_i,
  input  logic             spike_valid_i,
  input  logic             spike_i,
  input  logic [IDX_W-1:0] neuron_idx_i,
  input  logic             last_neuron_i,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [IDX_W+1:0] evt_data_o,
  output logic [CNT_W-1:0] spike_count_o,
  output logic             overflow_o,
  output logic             busy_o,
  output logic             sweep_done_o
);

  localparam int W = IDX_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(2 ** IDX_W);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_base_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic             ovf_r;
  logic             ovf_nxt_s;
  logic             done_r;
  logic             done_nxt_s;
  logic             busy_r;
  logic             push_req_s;
  logic             push_ok_s;
  logic             push_drop_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;
  logic [W-1:0]     word_s;
  logic [W-1:0]     head_s;

  // Only fired neurons and the end-of-sweep neuron produce events.
  assign push_req_s  = spike_valid_i && (spike_i || last_neuron_i);
  // Acceptance depends on occupancy at cycle start only: a same-cycle pop
  // does not make room.
  assign push_ok_s   = push_req_s && !full_s;
  assign push_drop_s = push_req_s && full_s;
  assign word_s      = {last_neuron_i, spike_i, neuron_idx_i};
  assign pop_s       = !empty_s && evt_ready_i;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (W)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (push_ok_s),
    .wr_data_i (word_s),
    .rd_en_i   (pop_s),
    .rd_data_o (head_s),
    .full_o    (full_s),
    .empty_o   (empty_s)
  );

  assign evt_valid_o   = !empty_s;
  assign evt_data_o    = head_s;
  assign spike_count_o = count_r;
  assign overflow_o    = ovf_r;
  assign busy_o        = busy_r;
  assign sweep_done_o  = done_r;

  // Image clear is applied first, then the current cycle's spike/drop.
  always_comb begin
    count_base_s = new_image_packet_i ? {CNT_W{1'b0}} : count_r;
    if (push_ok_s && spike_i && (count_base_s != CNT_MAX)) begin
      count_nxt_s = count_base_s + CNT_W'(1);
    end else begin
      count_nxt_s = count_base_s;
    end
    ovf_nxt_s = (new_image_packet_i ? 1'b0 : ovf_r) | push_drop_s;
  end

  // Sweep FSM next-state and done pulse.
  always_comb begin
    state_nxt_s = state_r;
    done_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (spike_valid_i) begin
          state_nxt_s = SWEEP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SWEEP: begin
        if (spike_valid_i && last_neuron_i) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = SWEEP;
        end
      end
      DRAIN: begin
        // A new sweep overlapping the drain takes priority over finishing.
        if (spike_valid_i && !last_neuron_i) begin
          state_nxt_s = SWEEP;
        end else if (spike_valid_i) begin
          state_nxt_s = DRAIN;
        end else if (empty_s) begin
          state_nxt_s = IDLE;
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, counter, status and pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      count_r <= {CNT_W{1'b0}};
      ovf_r   <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      ovf_r   <= ovf_nxt_s;
      done_r  <= done_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
    end
  end

endmodule
